// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer/compare peripheral: prescaled counter, compare match
// flag with level interrupt, one-shot or periodic operation.
module bus_timer #(
   parameter int          PSW       = 16,
   parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  addr,
   input  logic        ren,
   output logic [31:0] rdata,
   output logic        rd_valid,
   input  logic        wen,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   output logic        irq
);

   localparam logic [2:0] R_CTRL = 3'd0;
   localparam logic [2:0] R_PRE  = 3'd1;
   localparam logic [2:0] R_CNT  = 3'd2;
   localparam logic [2:0] R_CMP  = 3'd3;
   localparam logic [2:0] R_STS  = 3'd4;

   logic [2:0]     ctrl_q, ctrl_d;      // {IRQ_EN, PERIODIC, EN}
   logic [PSW-1:0] presc_q, presc_d;
   logic [PSW-1:0] pcnt_q, pcnt_d;
   logic [31:0]    count_q, count_d;
   logic [31:0]    cmp_q, cmp_d;
   logic           match_q, match_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           rvld_q;

   logic [2:0]  sel;
   logic        wr_any, count_wr, tick;
   logic [31:0] presc_ext, pw, nxt;
   logic        unused_addr;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   assign sel         = addr[4:2];
   assign unused_addr = ^addr[1:0];
   assign wr_any      = wen && (wmask != 4'd0);
   assign count_wr    = wr_any && (sel == R_CNT);
   assign tick        = ctrl_q[0] && (pcnt_q == '0);
   assign nxt         = count_q + 32'd1;

   always_comb begin
      presc_ext = '0;
      presc_ext[PSW-1:0] = presc_q;
      case (sel)
         R_CTRL:  rdata_d = {29'd0, ctrl_q};
         R_PRE:   rdata_d = presc_ext;
         R_CNT:   rdata_d = count_q;
         R_CMP:   rdata_d = cmp_q;
         R_STS:   rdata_d = {31'd0, match_q};
         default: rdata_d = 32'd0;
      endcase
   end

   always_comb begin
      ctrl_d  = ctrl_q;
      presc_d = presc_q;
      count_d = count_q;
      cmp_d   = cmp_q;
      match_d = match_q;
      pw      = merge(presc_ext, wdata, wmask);
      if (wr_any) begin
         case (sel)
            R_CTRL: if (wmask[0]) ctrl_d = wdata[2:0];
            R_PRE:  presc_d = pw[PSW-1:0];
            R_CNT:  count_d = merge(count_q, wdata, wmask);
            R_CMP:  cmp_d   = merge(cmp_q, wdata, wmask);
            R_STS:  if (wmask[0] && wdata[0]) match_d = 1'b0;
            default: ;
         endcase
      end
      // A bus write to COUNT or one that clears EN swallows a coincident tick.
      if (tick && !count_wr && ctrl_d[0]) begin
         if (nxt == cmp_q) begin
            match_d = 1'b1;
            if (ctrl_q[1]) count_d = 32'd0;
            else begin
               count_d   = nxt;
               ctrl_d[0] = 1'b0;
            end
         end else begin
            count_d = nxt;
         end
      end
      if (!ctrl_d[0] || !ctrl_q[0]) pcnt_d = presc_d;
      else if (pcnt_q == '0)        pcnt_d = presc_q;
      else                          pcnt_d = pcnt_q - {{(PSW-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q  <= '0;
         presc_q <= '0;
         pcnt_q  <= '0;
         count_q <= '0;
         cmp_q   <= RESET_CMP;
         match_q <= 1'b0;
         rdata_q <= '0;
         rvld_q  <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
         rvld_q  <= ren;
         if (ren) rdata_q <= rdata_d;
      end
   end

   assign rdata    = rdata_q;
   assign rd_valid = rvld_q;
   assign irq      = match_q & ctrl_q[2];

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: reset, one-shot, periodic, wrap, byte masks and
// same-edge collisions, each with hand-computed expectations.
module tb_bus_timer;

   localparam logic [4:0] A_CTRL = 5'h00;
   localparam logic [4:0] A_PRE  = 5'h04;
   localparam logic [4:0] A_CNT  = 5'h08;
   localparam logic [4:0] A_CMP  = 5'h0C;
   localparam logic [4:0] A_STS  = 5'h10;

   logic        clk, rst, ren, wen, rd_valid, irq;
   logic [4:0]  addr;
   logic [31:0] wdata, rdata;
   logic [3:0]  wmask;
   int          nvec, nerr;

   bus_timer #(.PSW(16), .RESET_CMP(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst), .addr(addr), .ren(ren), .rdata(rdata), .rd_valid(rd_valid),
      .wen(wen), .wdata(wdata), .wmask(wmask), .irq(irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic stp();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
      addr = a; wdata = d; wmask = m; wen = 1'b1;
      @(posedge clk); #1;
      wen = 1'b0; wmask = 4'd0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic v);
      addr = a; ren = 1'b1;
      @(posedge clk); #1;
      ren = 1'b0; d = rdata; v = rd_valid;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      rst = 1'b1;
      repeat (3) stp();
      rst = 1'b0;
      stp();
      nvec++; if (rdata !== 32'd0 || rd_valid !== 1'b0 || irq !== 1'b0) begin nerr++; $display("FAIL reset_outputs got %h/%b/%b exp 0/0/0", rdata, rd_valid, irq); end
      wr(A_CMP, 32'd1, 4'hF);
      wr(A_CTRL, 32'd5, 4'hF);
      stp();
      nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL pre_reset_irq got %b exp 1", irq); end
      wr(A_CNT, 32'h1234, 4'hF);
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'h1234 || v !== 1'b1) begin nerr++; $display("FAIL pre_reset_count got %h/%b exp 00001234/1", d, v); end
      addr = A_CNT; ren = 1'b1;
      #3 rst = 1'b1;
      #1;
      nvec++; if (rdata !== 32'd0 || rd_valid !== 1'b0 || irq !== 1'b0) begin nerr++; $display("FAIL async_reset_outputs got %h/%b/%b exp 0/0/0", rdata, rd_valid, irq); end
      @(posedge clk); #1;
      nvec++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL dropped_rd_valid got %b exp 0", rd_valid); end
      ren = 1'b0; rst = 1'b0;
      stp();
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL reset_count got %h exp 00000000", d); end
      rd(A_CMP, d, v);
      nvec++; if (d !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL reset_compare got %h exp ffffffff", d); end
      rd(A_CTRL, d, v);
      nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL reset_ctrl got %h exp 00000000", d); end
      rd(A_STS, d, v);
      nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL reset_status got %h exp 00000000", d); end
      rd(A_PRE, d, v);
      nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL reset_prescale got %h exp 00000000", d); end
   endtask

   task automatic test_oneshot();
      logic [31:0] d; logic v;
      wr(A_PRE, 32'd3, 4'hF);
      wr(A_CMP, 32'd5, 4'hF);
      wr(A_CTRL, 32'd5, 4'hF);
      repeat (19) stp();
      nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL oneshot_irq_early got %b exp 0", irq); end
      stp();
      nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL oneshot_irq_at_20 got %b exp 1", irq); end
      rd(A_STS, d, v);
      nvec++; if (d !== 32'd1) begin nerr++; $display("FAIL oneshot_match got %h exp 00000001", d); end
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'd5) begin nerr++; $display("FAIL oneshot_count got %h exp 00000005", d); end
      rd(A_CTRL, d, v);
      nvec++; if (d !== 32'd4) begin nerr++; $display("FAIL oneshot_en_cleared got %h exp 00000004", d); end
      repeat (10) stp();
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'd5) begin nerr++; $display("FAIL oneshot_stopped got %h exp 00000005", d); end
   endtask

   task automatic test_periodic();
      logic [31:0] d; logic v;
      wr(A_STS, 32'd1, 4'h1);
      rd(A_STS, d, v);
      nvec++; if (d !== 32'd0 || irq !== 1'b0) begin nerr++; $display("FAIL w1c_clear got %h/%b exp 00000000/0", d, irq); end
      wr(A_PRE, 32'd0, 4'hF);
      wr(A_CMP, 32'd4, 4'hF);
      wr(A_CNT, 32'd0, 4'hF);
      wr(A_CTRL, 32'd3, 4'hF);
      for (int i = 0; i < 8; i++) begin
         rd(A_CNT, d, v);
         nvec++; if (d !== 32'(i % 4) || v !== 1'b1 || irq !== 1'b0) begin nerr++; $display("FAIL periodic_seq[%0d] got %h/%b/%b exp %h/1/0", i, d, v, irq, 32'(i % 4)); end
      end
      rd(A_STS, d, v);
      nvec++; if (d !== 32'd1 || irq !== 1'b0) begin nerr++; $display("FAIL periodic_match got %h/%b exp 00000001/0", d, irq); end
      wr(A_CTRL, 32'd0, 4'hF);
   endtask

   task automatic test_wrap();
      logic [31:0] d; logic v;
      wr(A_STS, 32'd1, 4'h1);
      wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
      wr(A_CMP, 32'd0, 4'hF);
      wr(A_CTRL, 32'd1, 4'hF);
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL wrap_start got %h exp fffffffe", d); end
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL wrap_tick1 got %h exp ffffffff", d); end
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL wrap_tick2 got %h exp 00000000", d); end
      rd(A_STS, d, v);
      nvec++; if (d !== 32'd1) begin nerr++; $display("FAIL wrap_match got %h exp 00000001", d); end
      rd(A_CTRL, d, v);
      nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL wrap_oneshot_stop got %h exp 00000000", d); end
   endtask

   task automatic test_masks();
      logic [31:0] d; logic v;
      wr(A_CMP, 32'h1122_3344, 4'hF);
      wr(A_CMP, 32'hAABB_CCDD, 4'b0101);
      rd(A_CMP, d, v);
      nvec++; if (d !== 32'h11BB_33DD || v !== 1'b1) begin nerr++; $display("FAIL mask_0101 got %h/%b exp 11bb33dd/1", d, v); end
      wr(A_CMP, 32'd0, 4'h0);
      rd(A_CMP, d, v);
      nvec++; if (d !== 32'h11BB_33DD) begin nerr++; $display("FAIL mask_none got %h exp 11bb33dd", d); end
      wr(A_PRE, 32'hFFFF_FFFF, 4'hF);
      rd(A_PRE, d, v);
      nvec++; if (d !== 32'h0000_FFFF) begin nerr++; $display("FAIL prescale_width got %h exp 0000ffff", d); end
      wr(A_PRE, 32'd0, 4'hF);
      wr(5'h14, 32'hFFFF_FFFF, 4'hF);
      rd(5'h14, d, v);
      nvec++; if (d !== 32'd0 || v !== 1'b1) begin nerr++; $display("FAIL unmapped_14 got %h/%b exp 00000000/1", d, v); end
      rd(5'h1C, d, v);
      nvec++; if (d !== 32'd0 || v !== 1'b1) begin nerr++; $display("FAIL unmapped_1c got %h/%b exp 00000000/1", d, v); end
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'd0 || v !== 1'b1) begin nerr++; $display("FAIL b2b_first got %h/%b exp 00000000/1", d, v); end
      rd(A_CMP, d, v);
      nvec++; if (d !== 32'h11BB_33DD || v !== 1'b1) begin nerr++; $display("FAIL b2b_second got %h/%b exp 11bb33dd/1", d, v); end
      stp();
      nvec++; if (rd_valid !== 1'b0 || rdata !== 32'h11BB_33DD) begin nerr++; $display("FAIL rdata_hold got %h/%b exp 11bb33dd/0", rdata, rd_valid); end
   endtask

   task automatic test_collide();
      logic [31:0] d; logic v;
      wr(A_STS, 32'd1, 4'h1);
      wr(A_PRE, 32'd0, 4'hF);
      wr(A_CMP, 32'd3, 4'hF);
      wr(A_CNT, 32'd0, 4'hF);
      wr(A_CTRL, 32'd3, 4'hF);
      stp(); stp();
      wr(A_STS, 32'd1, 4'h1);
      rd(A_STS, d, v);
      nvec++; if (d !== 32'd1) begin nerr++; $display("FAIL set_beats_w1c got %h exp 00000001", d); end
      wr(A_CNT, 32'h100, 4'hF);
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'h100) begin nerr++; $display("FAIL count_write_wins got %h exp 00000100", d); end
      wr(A_CTRL, 32'd0, 4'hF);
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'h101) begin nerr++; $display("FAIL en_clear_wins got %h exp 00000101", d); end
      rd(A_CNT, d, v);
      nvec++; if (d !== 32'h101) begin nerr++; $display("FAIL stopped_count got %h exp 00000101", d); end
      wr(A_STS, 32'd1, 4'h1);
      rd(A_STS, d, v);
      nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL w1c_idle got %h exp 00000000", d); end
   endtask

   initial begin
      nvec = 0; nerr = 0;
      rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; wmask = '0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_wrap();
      test_masks();
      test_collide();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 32-bit timer/compare peripheral on the CPU data bus, alongside the LED and UART blocks.
- Selected by the address decoder through gated ren/wen.
- Provides a prescaled free-running counter, a compare match flag with a level interrupt, and one-shot or periodic mode.
- Read-valid handshake is identical to the other bus peripherals.

Parameters:
PSW, 16, prescaler register width in bits
RESET_CMP, 32'hFFFF_FFFF, reset value of COMPARE

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
addr  input  5  byte address within block; addr[4:2] selects register, addr[1:0] ignored
ren  input  1  read strobe, already qualified by block select
rdata  output  32  read data
rd_valid  output  1  read data valid pulse
wen  input  1  write strobe, already qualified by block select
wdata  input  32  write data
wmask  input  4  byte-lane write enables, bit n covers wdata[8n+7:8n]
irq  output  1  level interrupt request

Behaviour:
- Reset (async, rst=1): the following are cleared immediately:
  - rdata=0, rd_valid=0, irq=0
  - CTRL=0, PRESCALE=0, COUNT=0, STATUS=0, prescaler counter=0
  - COMPARE=RESET_CMP
- Register map (addr[4:2]):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
  - 1 PRESCALE: bits[PSW-1:0], upper bits read 0.
  - 2 COUNT: R/W.
  - 3 COMPARE: R/W.
  - 4 STATUS: bit0 MATCH, write-1-to-clear.
  - 5-7: read 0, writes ignored.
- Writes:
  - Take effect on the clk edge where wen=1.
  - Only lanes with wmask bit set are updated; wmask=0 is a no-op.
  - STATUS clears only if lane 0 is enabled and wdata[0]=1.
- Reads:
  - rdata/rd_valid are registered. ren=1 in cycle N gives rd_valid=1 and rdata=register value sampled at edge N in cycle N+1.
  - rd_valid is high for exactly one cycle per ren cycle; back-to-back ren gives back-to-back valid.
  - rdata holds its last value when rd_valid=0.
  - Read side effects: none.
- Read with write in the same cycle: read returns the pre-write value.
- Prescaler:
  - While EN=1, an internal down-counter pcnt reloads from PRESCALE at 0, otherwise decrements.
  - tick=1 in each cycle where pcnt==0, giving one tick per PRESCALE+1 clocks.
  - PRESCALE=0 gives a tick every clock.
  - While EN=0, pcnt is held at PRESCALE and no ticks occur.
  - A CTRL write setting EN 0->1 loads pcnt=PRESCALE, so the first tick comes PRESCALE+1 cycles after the write edge.
- Counting on tick, with nxt=COUNT+1 mod 2^32 (wraps 0xFFFF_FFFF -> 0):
  - nxt!=COMPARE: COUNT<=nxt.
  - nxt==COMPARE and PERIODIC=1: COUNT<=0, MATCH<=1.
  - nxt==COMPARE and PERIODIC=0: COUNT<=nxt, MATCH<=1, EN<=0 (one-shot stops).
- irq = MATCH & IRQ_EN, driven from flops only, no combinational path from bus inputs.
- Simultaneous events:
  - CPU write to COUNT in a tick cycle: write wins, tick increment discarded, match not evaluated that tick.
  - CPU write to CTRL clearing EN in a tick cycle: write wins, no count.
  - MATCH set and W1C in the same cycle: set wins, MATCH stays 1.
  - Write COMPARE equal to the current COUNT: no match until COUNT wraps the full 2^32 range.
- Reset mid-operation (including between ren and rd_valid): all state returns to reset values and the pending rd_valid is dropped.

Test Plan:
- Reset with COUNT=0x1234 set: assert rst mid-cycle -> all outputs 0 immediately, COUNT reads 0, COMPARE reads 0xFFFFFFFF.
- PRESCALE=3, COMPARE=5, CTRL=0b101 (EN, IRQ_EN, one-shot) -> MATCH=1 and irq=1 exactly 20 clocks after the CTRL write edge; COUNT stays 5; EN reads 0; no further counting.
- PERIODIC: PRESCALE=0, COMPARE=4, CTRL=0b011 -> COUNT sequence 1,2,3,0,1,... one per clock; MATCH set every 4th tick; irq stays 0 (IRQ_EN=0).
- Wrap: COUNT=0xFFFFFFFE, COMPARE=0, PRESCALE=0, EN=1 -> COUNT 0xFFFFFFFF, then 0 with MATCH=1 on the second tick.
- Byte masks: write 0xAABBCCDD to COMPARE with wmask=0b0101 over 0x11223344 -> reads 0x11BB33DD; read of addr 0x1C -> 0; rd_valid is one cycle after ren, for back-to-back reads too.
- Collisions: W1C STATUS on the same edge as a match -> MATCH stays 1; COUNT write of 0x100 on a tick edge -> COUNT reads 0x100, not 0x101.
